// File: rtl/seq_detect_pkg.sv
// Shared types and helpers for the programmable serial pattern detector.
package seq_detect_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HUNT = 2'd2
  } state_e;

  localparam int unsigned DEF_MAX_LEN = 8;
  localparam int unsigned DEF_CNT_W   = 8;
  localparam int unsigned MASK_W      = 32;

  // Ones in the low `len` bit positions; callers truncate to their pattern width.
  function automatic logic [MASK_W-1:0] len_mask(input int unsigned len);
    logic [MASK_W-1:0] m;
    for (int unsigned i = 0; i < MASK_W; i++) begin
      m[i] = (i < len);
    end
    return m;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear together with inc loads 1.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q, cnt_d;

  // NOTE: every variable assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = inc ? W'(1) : '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/seq_detect_prog.sv
// Programmable serial bit-pattern detector with overlap control and saturating match count.
// Define SEQ_DETECT_MEALY_EN for a combinational (same-cycle) match output; default is registered.
module seq_detect_prog
  import seq_detect_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int LEN_W   = $clog2(MAX_LEN) + 1,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  output logic               cfg_err,
  input  logic               in_valid,
  input  logic               in,
  output logic               match,
  output logic [CNT_W-1:0]   match_cnt,
  input  logic               cnt_clr,
  output logic               armed
);

  state_e             state_q, state_d;
  logic [MAX_LEN-1:0] pat_q, pat_d;
  // Only the previous MAX_LEN-1 bits are kept; the incoming bit completes the window.
  logic [MAX_LEN-2:0] hist_q, hist_d;
  logic [LEN_W-1:0]   len_q, len_d, fill_q, fill_d;
  logic               ovl_q, ovl_d;
  logic               armed_q, armed_d;
  logic               cfg_err_q, cfg_err_d;

  logic [MAX_LEN-1:0] cand, mask;
  logic [LEN_W-1:0]   fill_inc;
  logic               cfg_legal, accept, hit;

  assign cand      = {hist_q, in};
  assign mask      = MAX_LEN'(len_mask(32'(len_q)));
  assign fill_inc  = fill_q + LEN_W'(1);
  assign cfg_legal = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
  assign accept    = in_valid && !cfg_load && (state_q != IDLE);
  assign hit       = accept && (fill_inc >= len_q) && (((cand ^ pat_q) & mask) == '0);

  always_comb begin
    state_d   = state_q;
    pat_d     = pat_q;
    len_d     = len_q;
    ovl_d     = ovl_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    cfg_err_d = 1'b0;
    if (cfg_load) begin
      hist_d = '0;
      fill_d = '0;
      if (cfg_legal) begin
        state_d = FILL;
        pat_d   = cfg_pattern;
        len_d   = cfg_len;
        ovl_d   = cfg_overlap;
      end else begin
        state_d   = IDLE;
        cfg_err_d = 1'b1;
      end
    end else if (accept) begin
      if (hit && !ovl_q) begin
        hist_d  = '0;
        fill_d  = '0;
        state_d = FILL;
      end else begin
        hist_d  = cand[MAX_LEN-2:0];
        fill_d  = (fill_q < len_q) ? fill_inc : fill_q;
        state_d = (fill_d == len_q) ? HUNT : FILL;
      end
    end
    armed_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      pat_q     <= '0;
      len_q     <= '0;
      ovl_q     <= 1'b0;
      hist_q    <= '0;
      fill_q    <= '0;
      armed_q   <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pat_q     <= pat_d;
      len_q     <= len_d;
      ovl_q     <= ovl_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      armed_q   <= armed_d;
      cfg_err_q <= cfg_err_d;
    end
  end

`ifdef SEQ_DETECT_MEALY_EN
  assign match = hit;
`else
  logic match_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) match_q <= 1'b0;
    else      match_q <= hit;
  end

  assign match = match_q;
`endif

  sat_counter #(.W(CNT_W)) u_match_cnt (
    .clk   (clk),
    .rst_n (rst),
    .inc   (hit),
    .clr   (cnt_clr),
    .cnt   (match_cnt)
  );

  assign armed   = armed_q;
  assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_seq_detect_prog.sv
// Scoreboard bench for seq_detect_prog: queue-based reference model, directed cases plus random traffic.
module tb_seq_detect_prog;

  localparam int MAX_LEN = 8;
  localparam int LEN_W   = 4;
  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic               clk = 1'b0;
  logic               rst;
  logic               cfg_load;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               cfg_err;
  logic               in_valid;
  logic               in_bit;
  logic               match;
  logic [CNT_W-1:0]   match_cnt;
  logic               cnt_clr;
  logic               armed;

  seq_detect_prog #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .cfg_err     (cfg_err),
    .in_valid    (in_valid),
    .in          (in_bit),
    .match       (match),
    .match_cnt   (match_cnt),
    .cnt_clr     (cnt_clr),
    .armed       (armed)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             match;
    logic [CNT_W-1:0] cnt;
    logic             armed;
    logic             cfg_err;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: the accepted bits since the last load or non-overlapping hit.
  bit               m_bits[$];
  int               m_len   = 0;
  logic [MAX_LEN-1:0] m_pat = '0;
  bit               m_ovl   = 1'b0;
  bit               m_armed = 1'b0;
  int               m_cnt   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("match", 32'(match), 32'(e.match));
      check("match_cnt", 32'(match_cnt), 32'(e.cnt));
      check("armed", 32'(armed), 32'(e.armed));
      check("cfg_err", 32'(cfg_err), 32'(e.cfg_err));
    end
  end

  task automatic model_cycle(input logic ld, input logic [MAX_LEN-1:0] pat, input logic [LEN_W-1:0] len,
                             input logic ovl, input logic v, input logic b, input logic clr,
                             output exp_t e);
    bit hit;
    bit err;
    hit = 1'b0;
    err = 1'b0;
    if (ld) begin
      m_bits.delete();
      if (len >= 1 && len <= MAX_LEN) begin
        m_armed = 1'b1;
        m_pat   = pat;
        m_len   = int'(len);
        m_ovl   = ovl;
      end else begin
        m_armed = 1'b0;
        err     = 1'b1;
      end
    end else if (m_armed && v) begin
      m_bits.push_back(b);
      while (m_bits.size() > MAX_LEN) void'(m_bits.pop_front());
      if (m_bits.size() >= m_len) begin
        hit = 1'b1;
        for (int k = 0; k < m_len; k++) begin
          if (m_bits[m_bits.size() - 1 - k] != m_pat[k]) hit = 1'b0;
        end
      end
      if (hit && !m_ovl) m_bits.delete();
    end
    if (clr)                         m_cnt = hit ? 1 : 0;
    else if (hit && m_cnt < CNT_MAX) m_cnt++;
    e.match   = hit;
    e.cnt     = CNT_W'(m_cnt);
    e.armed   = m_armed;
    e.cfg_err = err;
  endtask

  task automatic step(input logic ld, input logic [MAX_LEN-1:0] pat, input logic [LEN_W-1:0] len,
                      input logic ovl, input logic v, input logic b, input logic clr);
    exp_t e;
    cfg_load    = ld;
    cfg_pattern = pat;
    cfg_len     = len;
    cfg_overlap = ovl;
    in_valid    = v;
    in_bit      = b;
    cnt_clr     = clr;
    model_cycle(ld, pat, len, ovl, v, b, clr, e);
    @(posedge clk);
    sb_q.push_back(e);
    #1;
    cfg_load = 1'b0;
    in_valid = 1'b0;
    cnt_clr  = 1'b0;
  endtask

  task automatic load(input logic [MAX_LEN-1:0] pat, input logic [LEN_W-1:0] len, input logic ovl);
    step(1'b1, pat, len, ovl, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic bit_in(input logic b);
    step(1'b0, '0, '0, 1'b0, 1'b1, b, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic clear_cnt();
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic feed(input logic [15:0] bits, input int n, input bit gaps);
    for (int i = n - 1; i >= 0; i--) begin
      bit_in(bits[i]);
      if (gaps) repeat ($urandom_range(0, 2)) idle();
    end
  endtask

  // Lets the monitor consume every pending expectation before a direct check.
  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  initial begin
    logic               r_ld, r_ovl, r_v, r_b, r_clr;
    logic [MAX_LEN-1:0] r_pat;
    logic [LEN_W-1:0]   r_len;

    rst         = 1'b0;
    cfg_load    = 1'b0;
    cfg_pattern = '0;
    cfg_len     = '0;
    cfg_overlap = 1'b0;
    in_valid    = 1'b0;
    in_bit      = 1'b0;
    cnt_clr     = 1'b0;
    #1;
    check("reset_match", 32'(match), 0);
    check("reset_cnt", 32'(match_cnt), 0);
    check("reset_armed", 32'(armed), 0);
    check("reset_cfg_err", 32'(cfg_err), 0);
    @(negedge clk);
    rst = 1'b1;

    // Legacy two-ones detector; upper pattern bits must be masked.
    load(8'b1010_0011, 4'd2, 1'b1);
    feed(16'b111101, 6, 1'b0);
    settle();
    check("legacy_cnt", 32'(match_cnt), 3);

    clear_cnt();
    load(8'h0B, 4'd4, 1'b1);
    feed(16'b1011011, 7, 1'b0);
    settle();
    check("overlap_cnt", 32'(match_cnt), 2);

    clear_cnt();
    load(8'b1111_1011, 4'd4, 1'b0);
    feed(16'b1011011, 7, 1'b0);
    settle();
    check("nonoverlap_cnt_a", 32'(match_cnt), 1);
    feed(16'b1011, 4, 1'b0);
    settle();
    check("nonoverlap_cnt_b", 32'(match_cnt), 2);

    clear_cnt();
    load(8'h0B, 4'd4, 1'b1);
    feed(16'b1011011, 7, 1'b1);
    settle();
    check("gaps_cnt", 32'(match_cnt), 2);

    load(8'h0B, 4'd0, 1'b1);
    settle();
    check("len0_armed", 32'(armed), 0);
    feed(16'b1011011, 7, 1'b0);
    settle();
    check("len0_cnt_kept", 32'(match_cnt), 2);
    load(8'h0B, 4'd9, 1'b1);
    settle();
    check("len9_armed", 32'(armed), 0);

    load(8'h01, 4'd1, 1'b1);
    bit_in(1'b1);
    step(1'b0, '0, '0, 1'b0, 1'b1, 1'b1, 1'b1);
    settle();
    check("clr_with_hit", 32'(match_cnt), 1);

    repeat (260) bit_in(1'b1);
    settle();
    check("saturate", 32'(match_cnt), CNT_MAX);

    // Asynchronous reset in the middle of a partial match.
    load(8'h0B, 4'd4, 1'b1);
    feed(16'b101, 3, 1'b0);
    settle();
    rst = 1'b0;
    #1;
    check("midrst_match", 32'(match), 0);
    check("midrst_cnt", 32'(match_cnt), 0);
    check("midrst_armed", 32'(armed), 0);
    check("midrst_cfg_err", 32'(cfg_err), 0);
    m_bits.delete();
    m_armed = 1'b0;
    m_cnt   = 0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    feed(16'b1011, 4, 1'b0);
    settle();
    check("post_rst_idle_cnt", 32'(match_cnt), 0);
    load(8'h0B, 4'd4, 1'b0);
    feed(16'b1011, 4, 1'b0);
    settle();
    check("post_rst_reload_cnt", 32'(match_cnt), 1);

    load(8'($urandom), 4'($urandom_range(1, 4)), 1'($urandom));
    for (int i = 0; i < 2000; i++) begin
      r_ld  = ($urandom % 40) == 0;
      r_pat = 8'($urandom);
      r_len = (($urandom % 8) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 4));
      r_ovl = 1'($urandom);
      r_v   = ($urandom % 4) != 0;
      r_b   = 1'($urandom);
      r_clr = ($urandom % 40) == 0;
      step(r_ld, r_pat, r_len, r_ovl, r_v, r_b, r_clr);
    end

    settle();
    settle();
    check("sb_drain", 32'(sb_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
